// File: rtl/lsu_split_access.sv
// Load/store byte-lane unit: positions store data and byte enables on the
// data bus, splits accesses that straddle a bus word into two beats, and
// extends load results. Illegal requests get a one-cycle error response.
//
// state | meaning
// IDLE  | ready for a request
// BEAT0 | first (or only) bus beat outstanding
// BEAT1 | second beat of a straddling access outstanding
// RESP  | resp_valid pulse with load result
// ERR   | resp_valid + resp_err pulse, no bus activity
module lsu_split_access #(
    parameter int BUS_W       = 32,
    parameter int ADDR_W      = 32,
    parameter int MISALIGN_EN = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_W-1:0]     req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  resp_valid_o,
    output logic [31:0]           resp_rdata_o,
    output logic                  resp_err_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [BUS_W-1:0]      mem_wdata_o,
    output logic [BUS_W/8-1:0]    mem_be_o,
    input  logic                  mem_ack_i,
    input  logic [BUS_W-1:0]      mem_rdata_i
);
    localparam int BUS_B = BUS_W / 8;
    localparam int OFS_W = $clog2(BUS_B);

    typedef enum logic [2:0] {S_IDLE, S_BEAT0, S_BEAT1, S_RESP, S_ERR} state_t;

    state_t               state_q;
    logic                 we_q;
    logic [2:0]           funct3_q;
    logic [OFS_W-1:0]     ofs_q;
    logic                 straddle_q;
    logic [2*BUS_W-1:0]   wwin_q;
    logic [2*BUS_B-1:0]   bwin_q;
    logic [BUS_W-1:0]     lo_q;

    logic [OFS_W-1:0]     req_ofs;
    logic [3:0]           size_b;
    logic [OFS_W+1:0]     ofs_sum;
    logic                 straddle_d;
    logic                 illegal_d;
    logic                 reject_d;
    logic [2*BUS_B-1:0]   bmask;
    logic [2*BUS_B-1:0]   bwin_d;
    logic [2*BUS_W-1:0]   wwin_d;
    logic [2*BUS_W-1:0]   rwin;
    logic [31:0]          rsh;
    logic [31:0]          rdata_d;

    // Decode the incoming request: legality, straddle and lane windows.
    always_comb begin
        req_ofs    = req_addr_i[OFS_W-1:0];
        size_b     = 4'd1 << req_funct3_i[1:0];
        ofs_sum    = {2'b00, req_ofs} + (OFS_W+2)'(size_b);
        straddle_d = ofs_sum > (OFS_W+2)'(BUS_B);
        illegal_d  = (req_funct3_i[1:0] == 2'b11)
                   | (!req_we_i && req_funct3_i[2] && req_funct3_i[1])
                   | (req_we_i && req_funct3_i[2]);
        reject_d   = illegal_d | (straddle_d && (MISALIGN_EN == 0));
        case (req_funct3_i[1:0])
            2'b00:   bmask = (2*BUS_B)'(1);
            2'b01:   bmask = (2*BUS_B)'(3);
            default: bmask = (2*BUS_B)'(15);
        endcase
        bwin_d = bmask << req_ofs;
        wwin_d = {{BUS_W{1'b0}}, BUS_W'(req_wdata_i)} << {req_ofs, 3'b000};
    end

    // Assemble the load result from the beat(s) just completing.
    always_comb begin
        rwin = (state_q == S_BEAT1) ? {mem_rdata_i, lo_q} : {{BUS_W{1'b0}}, mem_rdata_i};
        rsh  = 32'(rwin >> {ofs_q, 3'b000});
        case (funct3_q[1:0])
            2'b00:   rdata_d = funct3_q[2] ? {24'h0, rsh[7:0]}  : {{24{rsh[7]}}, rsh[7:0]};
            2'b01:   rdata_d = funct3_q[2] ? {16'h0, rsh[15:0]} : {{16{rsh[15]}}, rsh[15:0]};
            default: rdata_d = rsh;
        endcase
    end

    // Sequencer with registered handshake, bus and response outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= '0;
            resp_err_o   <= 1'b0;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            mem_be_o     <= '0;
            we_q         <= 1'b0;
            funct3_q     <= '0;
            ofs_q        <= '0;
            straddle_q   <= 1'b0;
            wwin_q       <= '0;
            bwin_q       <= '0;
            lo_q         <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        req_ready_o <= 1'b0;
                        we_q        <= req_we_i;
                        funct3_q    <= req_funct3_i;
                        ofs_q       <= req_ofs;
                        straddle_q  <= straddle_d;
                        wwin_q      <= req_we_i ? wwin_d : '0;
                        bwin_q      <= bwin_d;
                        if (reject_d) begin
                            state_q      <= S_ERR;
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                            resp_rdata_o <= '0;
                        end else begin
                            state_q     <= S_BEAT0;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= req_we_i;
                            mem_addr_o  <= {req_addr_i[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
                            mem_wdata_o <= req_we_i ? wwin_d[BUS_W-1:0] : '0;
                            mem_be_o    <= req_we_i ? bwin_d[BUS_B-1:0] : '1;
                        end
                    end
                end
                S_BEAT0: begin
                    if (mem_ack_i) begin
                        lo_q <= mem_rdata_i;
                        if (straddle_q) begin
                            state_q     <= S_BEAT1;
                            mem_addr_o  <= mem_addr_o + ADDR_W'(BUS_B);
                            mem_wdata_o <= wwin_q[2*BUS_W-1:BUS_W];
                            mem_be_o    <= we_q ? bwin_q[2*BUS_B-1:BUS_B] : '1;
                        end else begin
                            state_q      <= S_RESP;
                            mem_req_o    <= 1'b0;
                            mem_we_o     <= 1'b0;
                            mem_addr_o   <= '0;
                            mem_wdata_o  <= '0;
                            mem_be_o     <= '0;
                            resp_valid_o <= 1'b1;
                            resp_rdata_o <= we_q ? 32'h0 : rdata_d;
                        end
                    end
                end
                S_BEAT1: begin
                    if (mem_ack_i) begin
                        state_q      <= S_RESP;
                        mem_req_o    <= 1'b0;
                        mem_we_o     <= 1'b0;
                        mem_addr_o   <= '0;
                        mem_wdata_o  <= '0;
                        mem_be_o     <= '0;
                        resp_valid_o <= 1'b1;
                        resp_rdata_o <= we_q ? 32'h0 : rdata_d;
                    end
                end
                S_RESP, S_ERR: begin
                    state_q      <= S_IDLE;
                    resp_valid_o <= 1'b0;
                    resp_err_o   <= 1'b0;
                    resp_rdata_o <= '0;
                    req_ready_o  <= 1'b1;
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_o <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_split_access.sv
// Directed bench for lsu_split_access: 32-bit bus with splitting, 64-bit bus
// with splitting, and 32-bit bus with splitting disabled.
module tb_lsu_split_access;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // instance a: BUS_W=32, MISALIGN_EN=1
    logic        a_req_valid = 0, a_req_ready, a_req_we = 0;
    logic [2:0]  a_req_funct3 = 0;
    logic [31:0] a_req_addr = 0, a_req_wdata = 0;
    logic        a_resp_valid, a_resp_err, a_mem_req, a_mem_we, a_mem_ack = 0;
    logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata = 0;
    logic [3:0]  a_mem_be;

    // instance b: BUS_W=64, MISALIGN_EN=1
    logic        b_req_valid = 0, b_req_ready, b_req_we = 0;
    logic [2:0]  b_req_funct3 = 0;
    logic [31:0] b_req_addr = 0, b_req_wdata = 0;
    logic        b_resp_valid, b_resp_err, b_mem_req, b_mem_we, b_mem_ack = 0;
    logic [31:0] b_resp_rdata, b_mem_addr;
    logic [63:0] b_mem_wdata, b_mem_rdata = 0;
    logic [7:0]  b_mem_be;

    // instance c: BUS_W=32, MISALIGN_EN=0
    logic        c_req_valid = 0, c_req_ready, c_req_we = 0;
    logic [2:0]  c_req_funct3 = 0;
    logic [31:0] c_req_addr = 0, c_req_wdata = 0;
    logic        c_resp_valid, c_resp_err, c_mem_req, c_mem_we, c_mem_ack = 0;
    logic [31:0] c_resp_rdata, c_mem_addr, c_mem_wdata, c_mem_rdata = 0;
    logic [3:0]  c_mem_be;

    lsu_split_access #(.BUS_W(32), .ADDR_W(32), .MISALIGN_EN(1)) u_a (
        .clk_i(clk), .reset_i(rst), .req_valid_i(a_req_valid), .req_ready_o(a_req_ready),
        .req_we_i(a_req_we), .req_funct3_i(a_req_funct3), .req_addr_i(a_req_addr),
        .req_wdata_i(a_req_wdata), .resp_valid_o(a_resp_valid), .resp_rdata_o(a_resp_rdata),
        .resp_err_o(a_resp_err), .mem_req_o(a_mem_req), .mem_we_o(a_mem_we),
        .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata), .mem_be_o(a_mem_be),
        .mem_ack_i(a_mem_ack), .mem_rdata_i(a_mem_rdata));

    lsu_split_access #(.BUS_W(64), .ADDR_W(32), .MISALIGN_EN(1)) u_b (
        .clk_i(clk), .reset_i(rst), .req_valid_i(b_req_valid), .req_ready_o(b_req_ready),
        .req_we_i(b_req_we), .req_funct3_i(b_req_funct3), .req_addr_i(b_req_addr),
        .req_wdata_i(b_req_wdata), .resp_valid_o(b_resp_valid), .resp_rdata_o(b_resp_rdata),
        .resp_err_o(b_resp_err), .mem_req_o(b_mem_req), .mem_we_o(b_mem_we),
        .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata), .mem_be_o(b_mem_be),
        .mem_ack_i(b_mem_ack), .mem_rdata_i(b_mem_rdata));

    lsu_split_access #(.BUS_W(32), .ADDR_W(32), .MISALIGN_EN(0)) u_c (
        .clk_i(clk), .reset_i(rst), .req_valid_i(c_req_valid), .req_ready_o(c_req_ready),
        .req_we_i(c_req_we), .req_funct3_i(c_req_funct3), .req_addr_i(c_req_addr),
        .req_wdata_i(c_req_wdata), .resp_valid_o(c_resp_valid), .resp_rdata_o(c_resp_rdata),
        .resp_err_o(c_resp_err), .mem_req_o(c_mem_req), .mem_we_o(c_mem_we),
        .mem_addr_o(c_mem_addr), .mem_wdata_o(c_mem_wdata), .mem_be_o(c_mem_be),
        .mem_ack_i(c_mem_ack), .mem_rdata_i(c_mem_rdata));

    // Present one request for one cycle; returns at the negedge after acceptance.
    task automatic drive_a(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        a_req_valid = 1; a_req_we = we; a_req_funct3 = f3; a_req_addr = addr; a_req_wdata = wd;
        @(negedge clk);
        a_req_valid = 0;
    endtask

    task automatic drive_b(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        b_req_valid = 1; b_req_we = we; b_req_funct3 = f3; b_req_addr = addr; b_req_wdata = wd;
        @(negedge clk);
        b_req_valid = 0;
    endtask

    task automatic drive_c(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        c_req_valid = 1; c_req_we = we; c_req_funct3 = f3; c_req_addr = addr; c_req_wdata = wd;
        @(negedge clk);
        c_req_valid = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        rst = 0;
        checks++; if (a_req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", a_req_ready); end
        checks++; if (a_mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%b exp=0", a_mem_req); end
        checks++; if (a_resp_valid !== 1'b0 || a_resp_err !== 1'b0) begin failures++; $display("FAIL rst_resp got=%b%b exp=00", a_resp_valid, a_resp_err); end
        checks++; if (a_mem_be !== 4'h0 || a_mem_addr !== 32'h0 || a_mem_wdata !== 32'h0 || a_resp_rdata !== 32'h0) begin
            failures++; $display("FAIL rst_outs got be=%h addr=%h wd=%h rd=%h exp=0", a_mem_be, a_mem_addr, a_mem_wdata, a_resp_rdata); end
        checks++; if (b_req_ready !== 1'b1 || c_req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_bc got=%b%b exp=11", b_req_ready, c_req_ready); end
    endtask

    task automatic test_load_byte();
        drive_a(0, 3'b000, 32'h103, 32'h0);
        checks++; if (a_mem_req !== 1'b1 || a_mem_we !== 1'b0) begin failures++; $display("FAIL lb_req got=%b%b exp=10", a_mem_req, a_mem_we); end
        checks++; if (a_mem_addr !== 32'h100) begin failures++; $display("FAIL lb_addr got=%h exp=00000100", a_mem_addr); end
        checks++; if (a_mem_be !== 4'b1111) begin failures++; $display("FAIL lb_be got=%b exp=1111", a_mem_be); end
        checks++; if (a_req_ready !== 1'b0) begin failures++; $display("FAIL lb_ready got=%b exp=0", a_req_ready); end
        a_mem_ack = 1; a_mem_rdata = 32'h80AABBCC;
        @(negedge clk);
        a_mem_ack = 0;
        checks++; if (a_resp_valid !== 1'b1 || a_resp_err !== 1'b0) begin failures++; $display("FAIL lb_resp got=%b%b exp=10", a_resp_valid, a_resp_err); end
        checks++; if (a_resp_rdata !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_rdata got=%h exp=ffffff80", a_resp_rdata); end
        checks++; if (a_mem_req !== 1'b0) begin failures++; $display("FAIL lb_req_drop got=%b exp=0", a_mem_req); end
        @(negedge clk);
        checks++; if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1) begin failures++; $display("FAIL lb_idle got=%b%b exp=01", a_resp_valid, a_req_ready); end
    endtask

    task automatic test_lhu_wait();
        drive_a(0, 3'b101, 32'h106, 32'h0);
        @(negedge clk);
        checks++; if (a_mem_req !== 1'b1 || a_mem_addr !== 32'h104 || a_resp_valid !== 1'b0) begin
            failures++; $display("FAIL lhu_hold got req=%b addr=%h rv=%b exp=1 00000104 0", a_mem_req, a_mem_addr, a_resp_valid); end
        a_mem_ack = 1; a_mem_rdata = 32'h87654321;
        @(negedge clk);
        a_mem_ack = 0;
        checks++; if (a_resp_valid !== 1'b1 || a_resp_rdata !== 32'h00008765) begin
            failures++; $display("FAIL lhu_rdata got=%b/%h exp=1/00008765", a_resp_valid, a_resp_rdata); end
    endtask

    task automatic test_store_half();
        drive_a(1, 3'b001, 32'h202, 32'h1234ABCD);
        checks++; if (a_mem_we !== 1'b1 || a_mem_addr !== 32'h200) begin failures++; $display("FAIL sh_addr got=%b/%h exp=1/00000200", a_mem_we, a_mem_addr); end
        checks++; if (a_mem_be !== 4'b1100) begin failures++; $display("FAIL sh_be got=%b exp=1100", a_mem_be); end
        checks++; if (a_mem_wdata !== 32'hABCD0000) begin failures++; $display("FAIL sh_wdata got=%h exp=abcd0000", a_mem_wdata); end
        a_mem_ack = 1;
        @(negedge clk);
        a_mem_ack = 0;
        checks++; if (a_resp_valid !== 1'b1 || a_resp_rdata !== 32'h0 || a_mem_req !== 1'b0) begin
            failures++; $display("FAIL sh_resp got rv=%b rd=%h req=%b exp=1 0 0", a_resp_valid, a_resp_rdata, a_mem_req); end
    endtask

    task automatic test_lw_straddle();
        drive_a(0, 3'b010, 32'h2, 32'h0);
        checks++; if (a_mem_addr !== 32'h0 || a_mem_be !== 4'hF) begin failures++; $display("FAIL lws_b0 got=%h/%h exp=0/f", a_mem_addr, a_mem_be); end
        a_mem_ack = 1; a_mem_rdata = 32'h44332211;
        @(negedge clk);
        checks++; if (a_mem_req !== 1'b1 || a_mem_addr !== 32'h4 || a_resp_valid !== 1'b0) begin
            failures++; $display("FAIL lws_b1 got req=%b addr=%h rv=%b exp=1 00000004 0", a_mem_req, a_mem_addr, a_resp_valid); end
        a_mem_rdata = 32'h88776655;
        @(negedge clk);
        a_mem_ack = 0;
        checks++; if (a_resp_valid !== 1'b1 || a_resp_rdata !== 32'h66554433) begin
            failures++; $display("FAIL lws_rdata got=%b/%h exp=1/66554433", a_resp_valid, a_resp_rdata); end
    endtask

    task automatic test_wrap_lh();
        drive_a(0, 3'b001, 32'hFFFFFFFF, 32'h0);
        checks++; if (a_mem_addr !== 32'hFFFFFFFC) begin failures++; $display("FAIL wrap_b0 got=%h exp=fffffffc", a_mem_addr); end
        a_mem_ack = 1; a_mem_rdata = 32'hAA000000;
        @(negedge clk);
        checks++; if (a_mem_addr !== 32'h0 || a_mem_req !== 1'b1) begin failures++; $display("FAIL wrap_b1 got=%h/%b exp=0/1", a_mem_addr, a_mem_req); end
        a_mem_rdata = 32'h000000BB;
        @(negedge clk);
        a_mem_ack = 0;
        checks++; if (a_resp_rdata !== 32'hFFFFBBAA) begin failures++; $display("FAIL wrap_rdata got=%h exp=ffffbbaa", a_resp_rdata); end
    endtask

    task automatic test_illegal();
        drive_a(0, 3'b011, 32'h0, 32'h0);
        checks++; if (a_resp_valid !== 1'b1 || a_resp_err !== 1'b1 || a_mem_req !== 1'b0 || a_resp_rdata !== 32'h0) begin
            failures++; $display("FAIL ill_f3 got rv=%b err=%b req=%b rd=%h exp=1 1 0 0", a_resp_valid, a_resp_err, a_mem_req, a_resp_rdata); end
        @(negedge clk);
        checks++; if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1 || a_mem_req !== 1'b0) begin
            failures++; $display("FAIL ill_after got rv=%b rdy=%b req=%b exp=0 1 0", a_resp_valid, a_req_ready, a_mem_req); end
        drive_a(1, 3'b100, 32'h10, 32'h55);
        checks++; if (a_resp_err !== 1'b1 || a_mem_req !== 1'b0) begin failures++; $display("FAIL ill_store got err=%b req=%b exp=1 0", a_resp_err, a_mem_req); end
        drive_a(0, 3'b110, 32'h10, 32'h0);
        checks++; if (a_resp_err !== 1'b1 || a_mem_req !== 1'b0) begin failures++; $display("FAIL ill_lwu got err=%b req=%b exp=1 0", a_resp_err, a_mem_req); end
        @(negedge clk);
    endtask

    task automatic test_wide_store();
        drive_b(1, 3'b010, 32'h106, 32'hDEADBEEF);
        checks++; if (b_mem_addr !== 32'h100 || b_mem_be !== 8'hC0) begin failures++; $display("FAIL w64_b0 got=%h/%h exp=00000100/c0", b_mem_addr, b_mem_be); end
        checks++; if (b_mem_wdata[63:48] !== 16'hBEEF) begin failures++; $display("FAIL w64_d0 got=%h exp=beef", b_mem_wdata[63:48]); end
        b_mem_ack = 1;
        @(negedge clk);
        checks++; if (b_mem_req !== 1'b1 || b_mem_addr !== 32'h108 || b_mem_be !== 8'h03) begin
            failures++; $display("FAIL w64_b1 got req=%b addr=%h be=%h exp=1 00000108 03", b_mem_req, b_mem_addr, b_mem_be); end
        checks++; if (b_mem_wdata[15:0] !== 16'hDEAD) begin failures++; $display("FAIL w64_d1 got=%h exp=dead", b_mem_wdata[15:0]); end
        @(negedge clk);
        b_mem_ack = 0;
        checks++; if (b_resp_valid !== 1'b1 || b_resp_rdata !== 32'h0 || b_mem_req !== 1'b0) begin
            failures++; $display("FAIL w64_resp got rv=%b rd=%h req=%b exp=1 0 0", b_resp_valid, b_resp_rdata, b_mem_req); end
    endtask

    task automatic test_no_misalign();
        drive_c(0, 3'b010, 32'h1, 32'h0);
        checks++; if (c_resp_valid !== 1'b1 || c_resp_err !== 1'b1 || c_mem_req !== 1'b0) begin
            failures++; $display("FAIL nomis_err got rv=%b err=%b req=%b exp=1 1 0", c_resp_valid, c_resp_err, c_mem_req); end
        drive_c(0, 3'b010, 32'h4, 32'h0);
        checks++; if (c_mem_req !== 1'b1 || c_mem_addr !== 32'h4) begin failures++; $display("FAIL nomis_ok got=%b/%h exp=1/00000004", c_mem_req, c_mem_addr); end
        c_mem_ack = 1; c_mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        c_mem_ack = 0;
        checks++; if (c_resp_valid !== 1'b1 || c_resp_err !== 1'b0 || c_resp_rdata !== 32'hCAFEF00D) begin
            failures++; $display("FAIL nomis_rd got rv=%b err=%b rd=%h exp=1 0 cafef00d", c_resp_valid, c_resp_err, c_resp_rdata); end
    endtask

    task automatic test_back_to_back();
        drive_a(0, 3'b100, 32'h8, 32'h0);
        a_mem_ack = 1; a_mem_rdata = 32'h000000FF;
        @(negedge clk);
        a_mem_ack = 0;
        checks++; if (a_resp_rdata !== 32'h000000FF) begin failures++; $display("FAIL b2b_first got=%h exp=000000ff", a_resp_rdata); end
        drive_a(1, 3'b000, 32'h9, 32'h000000A5);
        checks++; if (a_mem_req !== 1'b1 || a_mem_be !== 4'b0010 || a_mem_wdata !== 32'h0000A500) begin
            failures++; $display("FAIL b2b_second got req=%b be=%b wd=%h exp=1 0010 0000a500", a_mem_req, a_mem_be, a_mem_wdata); end
        a_mem_ack = 1;
        @(negedge clk);
        a_mem_ack = 0;
        checks++; if (a_resp_valid !== 1'b1) begin failures++; $display("FAIL b2b_resp got=%b exp=1", a_resp_valid); end
    endtask

    task automatic test_reset_mid();
        drive_a(0, 3'b010, 32'h6, 32'h0);
        a_mem_ack = 1; a_mem_rdata = 32'h11111111;
        @(negedge clk);
        a_mem_ack = 0;
        checks++; if (a_mem_req !== 1'b1 || a_mem_addr !== 32'h8) begin failures++; $display("FAIL mid_b1 got=%b/%h exp=1/00000008", a_mem_req, a_mem_addr); end
        rst = 1;
        @(negedge clk);
        rst = 0;
        checks++; if (a_mem_req !== 1'b0 || a_req_ready !== 1'b1 || a_resp_valid !== 1'b0) begin
            failures++; $display("FAIL mid_reset got req=%b rdy=%b rv=%b exp=0 1 0", a_mem_req, a_req_ready, a_resp_valid); end
        @(negedge clk);
        checks++; if (a_resp_valid !== 1'b0 || a_mem_req !== 1'b0) begin failures++; $display("FAIL mid_after got rv=%b req=%b exp=0 0", a_resp_valid, a_mem_req); end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_lhu_wait();
        test_store_half();
        test_lw_straddle();
        test_wrap_lh();
        test_illegal();
        test_wide_store();
        test_no_misalign();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
